// File: rtl/bsg_mem_banked_1rw_arb_pkg.sv
// Shared types and helpers for the banked 1RW memory with read/write arbitration.
// Address decode helpers are generic over width so each instance picks its own split.
package bsg_mem_banked_1rw_arb_pkg;

    typedef enum logic [1:0] {
        OUT_EMPTY = 2'd0,
        OUT_FRESH = 2'd1,
        OUT_HOLD  = 2'd2
    } out_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bank_idx(
        input int unsigned addr,
        input bit          interleave,
        input int          idx_w,
        input int          off_w
    );
        int unsigned m;
        m = (32'd1 << idx_w) - 32'd1;
        return interleave ? (addr & m) : ((addr >> off_w) & m);
    endfunction

    function automatic int unsigned bank_off(
        input int unsigned addr,
        input bit          interleave,
        input int          idx_w,
        input int          off_w
    );
        int unsigned m;
        m = (32'd1 << off_w) - 32'd1;
        return interleave ? ((addr >> idx_w) & m) : (addr & m);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous SRAM behavioural macro.
// Read data appears the cycle after a read access and holds until the next read.
module bsg_mem_1rw_sync
    import bsg_mem_banked_1rw_arb_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p   = 16,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];

    // Array write or registered read; no access fires while in reset.
    always_ff @(posedge clk_i) begin
        if (v_i && !reset_i) begin
            if (w_i) begin
                mem[addr_i] <= data_i;
            end else begin
                data_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/bsg_mem_banked_rd_out.sv
// Read output stage: picks the accessed bank's data the cycle after a read,
// and parks it in a hold register until the consumer takes it.
module bsg_mem_banked_rd_out
    import bsg_mem_banked_1rw_arb_pkg::*;
#(
    parameter int width_p          = 64,
    parameter int num_depth_bank_p = 2,
    localparam int idx_w_lp = safe_clog2(num_depth_bank_p)
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      rd_acc,
    input  logic [idx_w_lp-1:0]                       rd_idx,
    input  logic [num_depth_bank_p-1:0][width_p-1:0]  bank_data,
    input  logic                                      r_yumi,
    output logic                                      r_v_o,
    output logic [width_p-1:0]                        r_data_o,
    output logic                                      busy
);

    out_state_e          state_r;
    out_state_e          state_n;
    logic [idx_w_lp-1:0] sel_r;
    logic [width_p-1:0]  hold_r;
    logic [width_p-1:0]  fresh_data;

    assign fresh_data = bank_data[sel_r];
    assign r_v_o      = (state_r != OUT_EMPTY) && reset_n;
    assign r_data_o   = (state_r == OUT_FRESH) ? fresh_data : hold_r;
    assign busy       = r_v_o && !r_yumi;

    // Next output state: a new read always lands fresh; otherwise drain or park.
    always_comb begin
        state_n = state_r;
        if (rd_acc) begin
            state_n = OUT_FRESH;
        end else begin
            unique case (state_r)
                OUT_FRESH: state_n = r_yumi ? OUT_EMPTY : OUT_HOLD;
                OUT_HOLD:  state_n = r_yumi ? OUT_EMPTY : OUT_HOLD;
                OUT_EMPTY: state_n = OUT_EMPTY;
                default:   state_n = OUT_EMPTY;
            endcase
        end
    end

    // Output state and bank select; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= OUT_EMPTY;
            sel_r   <= '0;
        end else begin
            state_r <= state_n;
            if (rd_acc) begin
                sel_r <= rd_idx;
            end
        end
    end

    // Capture the SRAM output before the bank can be reused by another read.
    always_ff @(posedge clk) begin
        if (reset_n && state_r == OUT_FRESH && state_n == OUT_HOLD) begin
            hold_r <= fresh_data;
        end
    end

endmodule

// File: rtl/bsg_mem_banked_1rw_arb.sv
// Logical 1R1W memory over a width x depth grid of single-port SRAM banks.
// Same-bank read/write collisions go to the write unless the read is starving.
module bsg_mem_banked_1rw_arb
    import bsg_mem_banked_1rw_arb_pkg::*;
#(
    parameter int width_p          = 64,
    parameter int els_p            = 64,
    parameter int num_width_bank_p = 1,
    parameter int num_depth_bank_p = 2,
    parameter int interleave_p     = 1,
    parameter int starve_limit_p   = 4,
    localparam int addr_width_lp   = safe_clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        w_v_i,
    input  logic [addr_width_lp-1:0]    w_addr_i,
    input  logic [width_p-1:0]          w_data_i,
    input  logic [num_width_bank_p-1:0] w_mask_i,
    output logic                        w_ready_o,
    input  logic                        r_v_i,
    input  logic [addr_width_lp-1:0]    r_addr_i,
    output logic                        r_ready_o,
    output logic                        r_v_o,
    output logic [width_p-1:0]          r_data_o,
    input  logic                        r_yumi_i
);

    localparam int IDX_W    = safe_clog2(num_depth_bank_p);
    localparam int OFF_W    = safe_clog2(els_p / num_depth_bank_p);
    localparam int SLICE_W  = width_p / num_width_bank_p;
    localparam int BANK_ELS = els_p / num_depth_bank_p;
    localparam int CNT_W    = safe_clog2(starve_limit_p + 1);
    localparam bit ILV      = (interleave_p != 0);

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;
    logic [OFF_W-1:0] w_off;
    logic [OFF_W-1:0] r_off;
    logic             busy;
    logic             r_req;
    logic             conflict;
    logic             rd_prio;
    logic             w_acc;
    logic             r_acc;
    logic [CNT_W-1:0] starve_cnt;

    logic [num_depth_bank_p-1:0][width_p-1:0] bank_data;

    assign w_idx = IDX_W'(bank_idx(32'(w_addr_i), ILV, IDX_W, OFF_W));
    assign r_idx = IDX_W'(bank_idx(32'(r_addr_i), ILV, IDX_W, OFF_W));
    assign w_off = OFF_W'(bank_off(32'(w_addr_i), ILV, IDX_W, OFF_W));
    assign r_off = OFF_W'(bank_off(32'(r_addr_i), ILV, IDX_W, OFF_W));

    assign r_req    = r_v_i && !busy;
    assign conflict = w_v_i && r_req && (w_idx == r_idx);
    assign rd_prio  = (starve_cnt == CNT_W'(starve_limit_p));

    assign w_ready_o = reset_n_i && !(conflict && rd_prio);
    assign r_ready_o = reset_n_i && !busy && !(conflict && !rd_prio);

    assign w_acc = w_v_i && w_ready_o;
    assign r_acc = r_v_i && r_ready_o;

    // Count consecutive lost collisions; any accepted read forgives the debt.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            starve_cnt <= '0;
        end else if (r_acc) begin
            starve_cnt <= '0;
        end else if (conflict && !rd_prio) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    for (genvar d = 0; d < num_depth_bank_p; d++) begin : g_d
        logic             w_sel;
        logic             r_sel;
        logic [OFF_W-1:0] addr;

        assign w_sel = w_acc && (w_idx == IDX_W'(d));
        assign r_sel = r_acc && (r_idx == IDX_W'(d));
        assign addr  = w_sel ? w_off : r_off;

        for (genvar s = 0; s < num_width_bank_p; s++) begin : g_s
            logic v;
            assign v = (w_sel && w_mask_i[s]) || r_sel;

            bsg_mem_1rw_sync #(
                .width_p (SLICE_W),
                .els_p   (BANK_ELS)
            ) bank (
                .clk_i   (clk_i),
                .reset_i (!reset_n_i),
                .data_i  (w_data_i[s*SLICE_W +: SLICE_W]),
                .addr_i  (addr),
                .v_i     (v),
                .w_i     (w_sel),
                .data_o  (bank_data[d][s*SLICE_W +: SLICE_W])
            );
        end
    end

    bsg_mem_banked_rd_out #(
        .width_p          (width_p),
        .num_depth_bank_p (num_depth_bank_p)
    ) rd_out (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .rd_acc    (r_acc),
        .rd_idx    (r_idx),
        .bank_data (bank_data),
        .r_yumi    (r_yumi_i),
        .r_v_o     (r_v_o),
        .r_data_o  (r_data_o),
        .busy      (busy)
    );

endmodule

// File: tb/tb_bsg_mem_banked_1rw_arb.sv
// Directed bench: interleaved (a) and high-bit-indexed (b) instances,
// 64 bits wide, 64 deep, 2 width slices x 4 depth banks.
module tb_bsg_mem_banked_1rw_arb;

    typedef struct {
        bit          b;
        bit          w_v;
        logic [5:0]  w_addr;
        logic [63:0] w_data;
        logic [1:0]  w_mask;
        bit          r_v;
        logic [5:0]  r_addr;
        bit          yumi;
        bit          e_wr;
        bit          e_rr;
        bit          e_rv;
        logic [63:0] e_d;
    } vec_t;

    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] P8   = 64'h0808_0808_0808_0808;
    localparam logic [63:0] P4   = 64'h0404_0404_0404_0404;
    localparam logic [63:0] PC   = 64'h0C0C_0C0C_0C0C_0C0C;
    localparam logic [63:0] P1   = 64'h0101_0101_0101_0101;
    localparam logic [63:0] F5   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] FA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] MX   = 64'h5555_5555_AAAA_AAAA;
    localparam logic [63:0] Z    = 64'h0;

    logic clk = 1'b0;
    logic reset_n;

    logic        wv_a, rv_a, y_a, wr_a, rr_a, rvo_a;
    logic [5:0]  wa_a, ra_a;
    logic [63:0] wd_a, rd_a;
    logic [1:0]  wm_a;
    logic        wv_b, rv_b, y_b, wr_b, rr_b, rvo_b;
    logic [5:0]  wa_b, ra_b;
    logic [63:0] wd_b, rd_b;
    logic [1:0]  wm_b;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    vec_t v;

    always #5 clk = ~clk;

    bsg_mem_banked_1rw_arb #(
        .width_p(64), .els_p(64), .num_width_bank_p(2),
        .num_depth_bank_p(4), .interleave_p(1), .starve_limit_p(4)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n),
        .w_v_i(wv_a), .w_addr_i(wa_a), .w_data_i(wd_a), .w_mask_i(wm_a),
        .w_ready_o(wr_a), .r_v_i(rv_a), .r_addr_i(ra_a), .r_ready_o(rr_a),
        .r_v_o(rvo_a), .r_data_o(rd_a), .r_yumi_i(y_a)
    );

    bsg_mem_banked_1rw_arb #(
        .width_p(64), .els_p(64), .num_width_bank_p(2),
        .num_depth_bank_p(4), .interleave_p(0), .starve_limit_p(4)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n),
        .w_v_i(wv_b), .w_addr_i(wa_b), .w_data_i(wd_b), .w_mask_i(wm_b),
        .w_ready_o(wr_b), .r_v_i(rv_b), .r_addr_i(ra_b), .r_ready_o(rr_b),
        .r_v_o(rvo_b), .r_data_o(rd_b), .r_yumi_i(y_b)
    );

    function automatic vec_t mk(
        input bit b, input bit wv, input int wa, input logic [63:0] wd,
        input int wm, input bit rv, input int ra, input bit y,
        input bit ewr, input bit err, input bit erv, input logic [63:0] ed
    );
        vec_t t;
        t.b = b; t.w_v = wv; t.w_addr = 6'(wa); t.w_data = wd;
        t.w_mask = 2'(wm); t.r_v = rv; t.r_addr = 6'(ra); t.yumi = y;
        t.e_wr = ewr; t.e_rr = err; t.e_rv = erv; t.e_d = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        wv_a = 0; wa_a = 0; wd_a = 0; wm_a = 0; rv_a = 0; ra_a = 0; y_a = 0;
        wv_b = 0; wa_b = 0; wd_b = 0; wm_b = 0; rv_b = 0; ra_b = 0; y_b = 0;
        if (t.b) begin
            wv_b = t.w_v; wa_b = t.w_addr; wd_b = t.w_data; wm_b = t.w_mask;
            rv_b = t.r_v; ra_b = t.r_addr; y_b = t.yumi;
        end else begin
            wv_a = t.w_v; wa_a = t.w_addr; wd_a = t.w_data; wm_a = t.w_mask;
            rv_a = t.r_v; ra_a = t.r_addr; y_a = t.yumi;
        end
    endtask

    task automatic run_vec(input bit rst_n, input vec_t t, input string nm);
        logic wr, rr, rvo;
        logic [63:0] rd;
        @(posedge clk);
        #1;
        reset_n = rst_n;
        drive(t);
        @(negedge clk);
        wr  = t.b ? wr_b : wr_a;
        rr  = t.b ? rr_b : rr_a;
        rvo = t.b ? rvo_b : rvo_a;
        rd  = t.b ? rd_b : rd_a;
        chk({nm, " w_ready"}, 64'(wr), 64'(t.e_wr));
        chk({nm, " r_ready"}, 64'(rr), 64'(t.e_rr));
        chk({nm, " r_v"}, 64'(rvo), 64'(t.e_rv));
        if (t.e_rv) chk({nm, " r_data"}, rd, t.e_d);
    endtask

    initial begin
        reset_n = 0;
        drive(mk(0, 1, 5, Z, 3, 1, 9, 0, 0, 0, 0, Z));
        wv_b = 1; rv_b = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst w_ready_a", 64'(wr_a), 0);
        chk("rst r_ready_a", 64'(rr_a), 0);
        chk("rst r_v_a", 64'(rvo_a), 0);
        chk("rst w_ready_b", 64'(wr_b), 0);
        chk("rst r_v_b", 64'(rvo_b), 0);

        tbl.push_back(mk(0, 1, 5, DEAD, 3, 0, 0, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 1, 8, P8, 3, 1, 5, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 1, 4, P4, 3, 1, 8, 1, 1, 0, 1, DEAD));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 8, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 4, 1, 1, 1, 1, P8));
        tbl.push_back(mk(0, 1, 12, PC, 3, 0, 0, 1, 1, 1, 1, P4));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 12, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 1, 1, P1, 3, 0, 0, 1, 1, 1, 1, PC));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 9 + 4 * k, 64'(k), 3, 1, 1, 0, 1, 0, 0, Z));
        tbl.push_back(mk(0, 1, 25, Z, 3, 1, 1, 0, 0, 1, 0, Z));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 1, 1, P1));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 5, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 8, 0, 1, 0, 1, DEAD));
        tbl.push_back(mk(0, 1, 13, PC, 3, 1, 8, 0, 1, 0, 1, DEAD));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 8, 0, 1, 0, 1, DEAD));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 8, 1, 1, 1, 1, DEAD));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 1, 1, P8));
        tbl.push_back(mk(0, 1, 6, F5, 3, 0, 0, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 1, 6, FA, 1, 0, 0, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 0, 0, Z, 0, 1, 6, 0, 1, 1, 0, Z));
        tbl.push_back(mk(0, 1, 2, Z, 0, 1, 6, 1, 1, 0, 1, MX));
        tbl.push_back(mk(0, 0, 0, Z, 0, 0, 0, 0, 1, 1, 0, Z));
        tbl.push_back(mk(1, 1, 'h30, F5, 3, 0, 0, 0, 1, 1, 0, Z));
        tbl.push_back(mk(1, 1, 'h30, FA, 1, 1, 'h31, 0, 1, 0, 0, Z));
        tbl.push_back(mk(1, 0, 0, Z, 0, 1, 'h30, 0, 1, 1, 0, Z));
        tbl.push_back(mk(1, 0, 0, Z, 0, 0, 0, 1, 1, 1, 1, MX));
        tbl.push_back(mk(1, 1, 'h01, P1, 3, 1, 'h02, 0, 1, 0, 0, Z));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(1, tbl[i], $sformatf("v%0d", i));
            if (i == 13) chk("starve_clear", 64'(dut_a.starve_cnt), 0);
        end

        run_vec(1, mk(0, 0, 0, Z, 0, 1, 5, 0, 1, 1, 0, Z), "h0");
        run_vec(1, mk(0, 0, 0, Z, 0, 0, 0, 0, 1, 0, 1, DEAD), "h1");
        run_vec(1, mk(0, 0, 0, Z, 0, 0, 0, 0, 1, 0, 1, DEAD), "h2");
        v = mk(0, 1, 9, Z, 3, 1, 1, 0, 0, 0, 0, Z);
        run_vec(0, v, "h3");
        run_vec(0, v, "h4");
        run_vec(1, mk(0, 0, 0, Z, 0, 0, 0, 0, 1, 1, 0, Z), "h5");

        v = mk(0, 1, 9, Z, 3, 1, 1, 0, 1, 0, 0, Z);
        for (int k = 0; k < 3; k++) run_vec(1, v, $sformatf("s%0d", k));
        run_vec(0, mk(0, 1, 9, Z, 3, 1, 1, 0, 0, 0, 0, Z), "s_rst");
        for (int k = 0; k < 5; k++) begin
            v = mk(0, 1, 9, Z, 3, 1, 1, 0, k < 4, k == 4, 0, Z);
            run_vec(1, v, $sformatf("p%0d", k));
        end
        run_vec(1, mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 1, 1, P1), "p_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_mem_banked_1rw_arb.md
# bsg_mem_banked_1rw_arb

Logical 1-read/1-write memory built from width×depth banks of single-port (1RW) synchronous SRAM, with valid/ready handshakes on both request channels. Read and write requests that target the same depth bank in the same cycle are arbitrated, with a starvation guard. Read data is held in an output stage until the consumer acknowledges it. It is the drop-in for wide/deep buffers (cache data arrays, NoC reorder buffers) where dual-port macros are too costly.

## Interface
- width_p, none (required), total data width; multiple of num_width_bank_p
- els_p, none (required), total depth; multiple of num_depth_bank_p; els_p/num_depth_bank_p a power of two
- num_width_bank_p, 1, width slices per depth bank
- num_depth_bank_p, 2, depth banks; power of two ≥2
- interleave_p, 1, 1: bank idx = addr low bits; 0: bank idx = addr high bits
- starve_limit_p, 4, consecutive lost conflicts before read gains priority; ≥1
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- w_v_i  in  1  write request
- w_addr_i  in  clog2(els_p)  write address
- w_data_i  in  width_p  write data
- w_mask_i  in  num_width_bank_p  per-width-slice write enable
- w_ready_o  out  1  write accepted when w_v_i & w_ready_o
- r_v_i  in  1  read request
- r_addr_i  in  clog2(els_p)  read address
- r_ready_o  out  1  read accepted when r_v_i & r_ready_o
- r_v_o  out  1  read data valid
- r_data_o  out  width_p  read data
- r_yumi_i  in  1  consumer takes r_data_o; only legal while r_v_o

## Operation
- Bank index/offset: interleave_p=1 uses idx=addr[0+:D], off=addr[D+:B]; interleave_p=0 uses idx=addr[B+:D], off=addr[0+:B].
- out_busy = r_v_o & ~r_yumi_i. Effective read request: r_req = r_v_i & ~out_busy.
- conflict = w_v_i & r_req & (w_idx == r_idx).
- No conflict: write accepted if w_v_i; read accepted if r_req; different banks access in parallel.
- Conflict: the write wins unless rd_prio. The loser's ready is low that cycle, and the loser bank is not enabled.
- starve_cnt: reset 0. Increments, saturating at starve_limit_p, on each conflict cycle lost by the read. Clears on any accepted read.
- rd_prio = (starve_cnt == starve_limit_p).
- Write with w_mask_i all zero is still accepted and consumes the bank.
- Output stage:
  - Accepted read at cycle N gives r_v_o=1 at N+1, with data from bank idx registered at N.
  - If there is no r_yumi_i at N+1, data is copied to a hold register. r_v_o stays 1 and r_data_o stays stable until yumi.
  - r_ready_o is 0 while out_busy.
- Read of an address written in the same cycle cannot occur: it is the same bank, so a conflict.
- A read in the cycle after a write to the same address returns the new data.
- Reset (reset_n_i=0 at a clock edge) gives r_v_o=0, starve_cnt=0, hold register empty. Any pending output is discarded. SRAM contents are unchanged or undefined; no bank enables fire during reset.

## Timing
- Read latency: exactly 1 cycle from acceptance to r_v_o when the output is free.
- Read throughput: 1/cycle with r_yumi_i asserted every valid cycle.
- w_ready_o and r_ready_o are combinational from w_v_i, r_v_i, addresses, r_v_o, r_yumi_i, starve_cnt. Valids never depend on readies.
- During reset, w_ready_o=0, r_ready_o=0, r_v_o=0.
- r_data_o is undefined when r_v_o=0.

## Structure
- No shared package needed. Index/offset widths are local params computed with `BSG_SAFE_CLOG2. Bank select is a local function of interleave_p.
- Banks: bsg_mem_1rw_sync (existing), width_p/num_width_bank_p wide, one per (width, depth) pair. v_i comes from arbitration; w_i selects write. Mask gating uses w_mask_i per width slice.
- One new sub-module: bsg_mem_banked_rd_out. It holds the fresh/hold flag, hold register, bank-select register and output mux, and exposes r_v_o, r_data_o, busy.

## Test plan
- Width 64, els 64, 2×4 banks, interleave 1. Write addr 5 = 0xDEAD_BEEF_0123_4567, then read 5 with yumi. Expect r_v_o one cycle after accept and data matching.
- Same cycle: write addr 4, read addr 8 (same bank 0). Expect w_ready_o=1, r_ready_o=0. Next cycle the read alone is accepted.
- Write to bank 1 every cycle, read addr 1 held. Expect read rejected 4 times, then the 5th cycle r_ready_o=1 and w_ready_o=0. starve_cnt returns to 0.
- Read accepted, r_yumi_i low for 3 cycles. Expect r_data_o stable, r_ready_o=0, new r_v_i ignored. Yumi on cycle 4 together with a new read gives back-to-back valid.
- w_mask_i=2'b01 with data 0xAAAA..., prior contents 0x5555.... Expect low slice updated, high slice unchanged. Repeat with interleave_p=0, address 0x30 mapping to bank 3.
- Assert reset_n_i=0 while r_v_o=1 and starve_cnt=3. Next cycle r_v_o=0, both readies 0. After release, the first conflict read loses 4 times before gaining priority.
